hazard_ctrl: RTL

Parametrised hazard and stall controller for the 5-stage pipelined MIPS core, sitting between the IF/ID and ID/EX pipeline registers and driving PC write-enable, IF/ID hold, and bubble/flush controls. It supports configurable multi-cycle load-use stalls and branch-operand stalls through a countdown state machine. It also flushes wrong-path fetches after a jump resolved in EX. Optional saturating hazard statistics counters can be compiled in.

---
 rtl/hazard_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS pipeline: load-use and branch-operand
// stalls via a countdown FSM, and wrong-path flush after an EX jump. Optional statistics: HAZARD_STATS_EN.
module hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int BR_STALL = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              idex_memread,
    input  logic              idex_regwr,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              idex_jump,
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic              ifid_uses_rt,
    input  logic              ifid_memwr,
    input  logic              ifid_branch,
    output logic              stall,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_flush,
    output logic              ifid_flush,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);

    // A branch waiting on a load can need up to 7+7 cycles, so the countdown needs 4 bits.
    localparam int REM_W = 4;

    if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_bad_load_lat
        $error("hazard_ctrl: LOAD_LAT must be in 1..7");
    end
    if (BR_STALL < 1 || BR_STALL > 7) begin : g_bad_br_stall
        $error("hazard_ctrl: BR_STALL must be in 1..7");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;

    logic             hit_rs, hit_rt;
    logic             br_on_load, load_use, br_on_alu, hazard;
    logic [REM_W-1:0] n_cycles;

    // ------------------------------------------------------------------
    // Hazard detection (purely combinational, used only in IDLE)
    // ------------------------------------------------------------------
    assign hit_rs = (ifid_rs == idex_rd) && (ifid_rs != '0);
    assign hit_rt = (ifid_rt == idex_rd) && (ifid_rt != '0);

    assign br_on_load = ifid_branch && idex_memread && (hit_rs || hit_rt);
    assign load_use   = idex_memread && (hit_rs || (ifid_uses_rt && hit_rt && !ifid_memwr));
    assign br_on_alu  = ifid_branch && idex_regwr && !idex_memread && (hit_rs || hit_rt);
    assign hazard     = br_on_load || load_use || br_on_alu;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        n_cycles = '0;
        if (br_on_load) begin
            n_cycles = REM_W'(LOAD_LAT + BR_STALL);
        end else if (load_use) begin
            n_cycles = REM_W'(LOAD_LAT);
        end else if (br_on_alu) begin
            n_cycles = REM_W'(BR_STALL);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                // The detect cycle is the first stall cycle; only the remainder is counted down.
                if (!idex_jump && hazard && (n_cycles > REM_W'(1))) begin
                    state_d = ST_STALL;
                    rem_d   = n_cycles - REM_W'(1);
                end
            end
            ST_STALL: begin
                if (rem_q == REM_W'(1)) begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                end else begin
                    rem_d = rem_q - REM_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        stall      = 1'b0;
        idex_flush = 1'b0;
        ifid_flush = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    // The IF/ID instruction behind a taken jump is wrong-path, so its hazards are moot.
                    if (idex_jump) begin
                        ifid_flush = 1'b1;
                    end else if (hazard) begin
                        stall      = 1'b1;
                        idex_flush = 1'b1;
                    end
                end
                ST_STALL: begin
                    stall      = 1'b1;
                    idex_flush = 1'b1;
                end
                default: begin
                    stall      = 1'b0;
                    idex_flush = 1'b0;
                end
            endcase
        end
    end

    assign pc_write   = ~stall;
    assign ifid_write = ~stall;

    // ------------------------------------------------------------------
    // Statistics counters (observe stall/flush only, never feed them)
    // ------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ifid_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule
